// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit framer.
//   - dout_type encodings seen by the downstream bit-order mapping stage
//   - framer FSM state encodings
//   - default header magic, idle word and fill word
package tx_frame_pkg;

    typedef enum logic [1:0] {
        TYPE_IDLE = 2'd0,   // idle between frames, or fill inside a frame
        TYPE_HDR  = 2'd1,
        TYPE_PAY  = 2'd2,
        TYPE_TRL  = 2'd3
    } dout_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_e;

    localparam logic [47:0] DEF_HDR_MAGIC = 48'hA5A5_5A5A_C3C3;
    localparam logic [63:0] DEF_IDLE_WORD = 64'h0707_0707_0707_0707;
    localparam logic [63:0] DEF_FILL_WORD = 64'hFEFE_FEFE_FEFE_FEFE;

endpackage

// File: rtl/tx_skid_fifo.sv
// Two-entry input buffer for the framer.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   s_data, s_valid   upstream word and its valid
//   s_ready           registered "not full"; low while in reset
//   rd_en             consumer pops the head entry (ignored when empty)
//   rd_data           head entry
//   rd_avail          buffer holds at least one word
module tx_skid_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_avail
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         ready_q, ready_d;
    logic         wr, rd;

    always_comb begin
        wr       = s_valid && ready_q;
        rd       = rd_en && (count_q != 2'd0);
        mem_d    = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = s_data;
        end
        wr_ptr_d = wr_ptr_q ^ wr;
        rd_ptr_d = rd_ptr_q ^ rd;
        count_d  = count_q + {1'b0, wr} - {1'b0, rd};
        // Ready is registered from next occupancy so it never admits a third word.
        ready_d  = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign s_ready  = ready_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_avail = (count_q != 2'd0);

endmodule

// File: rtl/tx_framer.sv
// Transmit framer: wraps a 64-bit payload stream into frames of
// header, FRAME_LEN payload words and an XOR checksum trailer, emitting
// one word every clock toward the bit-order mapping stage.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   en                  frame-start enable, looked at only when a frame could start
//   s_data/s_valid      payload input handshake
//   s_ready             registered ready from the input buffer
//   dout, dout_type     registered framed word and its type
//   seq                 sequence number of the current or next frame
//   underrun            sticky, set when a fill word has been emitted
module tx_framer
    import tx_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter logic [47:0] HDR_MAGIC = DEF_HDR_MAGIC,
    parameter logic [63:0] IDLE_WORD = DEF_IDLE_WORD,
    parameter logic [63:0] FILL_WORD = DEF_FILL_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [63:0] dout,
    output logic [1:0]  dout_type,
    output logic [15:0] seq,
    output logic        underrun
);

    localparam logic [15:0] LEN_W = 16'(FRAME_LEN);

    state_e      state_q, state_d;
    logic [63:0] dout_q, dout_d;
    dout_type_e  type_q, type_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] csum_q, csum_d;
    logic        underrun_q, underrun_d;
    logic        pop;
    logic [63:0] buf_data;
    logic        buf_avail;

    tx_skid_fifo #(.W(64)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .rd_en    (pop),
        .rd_data  (buf_data),
        .rd_avail (buf_avail)
    );

    always_comb begin
        state_d    = state_q;
        dout_d     = IDLE_WORD;
        type_d     = TYPE_IDLE;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && buf_avail) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                dout_d  = {HDR_MAGIC, seq_q};
                type_d  = TYPE_HDR;
                csum_d  = '0;
                cnt_d   = '0;
                state_d = PAY;
            end
            PAY: begin
                if (buf_avail) begin
                    pop    = 1'b1;
                    dout_d = buf_data;
                    type_d = TYPE_PAY;
                    csum_d = csum_q ^ buf_data;
                    cnt_d  = cnt_q + 16'd1;
                end else begin
                    // Fill keeps the line busy; it is not part of the checksum.
                    dout_d     = FILL_WORD;
                    underrun_d = 1'b1;
                end
                if (cnt_d == LEN_W) begin
                    state_d = TRL;
                end
            end
            TRL: begin
                dout_d  = csum_q;
                type_d  = TYPE_TRL;
                seq_d   = seq_q + 16'd1;
                state_d = (en && buf_avail) ? HDR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dout_q     <= IDLE_WORD;
            type_q     <= TYPE_IDLE;
            seq_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            type_q     <= type_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            underrun_q <= underrun_d;
        end
    end

    assign dout      = dout_q;
    assign dout_type = type_q;
    assign seq       = seq_q;
    assign underrun  = underrun_q;

endmodule
